// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decade counter slice.
//   BCD_W     : width of one BCD digit
//   BCD_MAX   : largest legal digit code (9)
//   BCD_MIN   : smallest legal digit code (0)
//   bcd_t     : one BCD digit
//   bcd_clamp : maps any 4-bit code onto 0..9 (codes above 9 become 9)
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic bcd_t bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage of the BCD counter.
//   clock      : system clock, rising edge
//   reset_n    : synchronous active-low reset, digit -> 0
//   en         : advance this digit one step in direction 'up'
//   up         : 1 = increment, 0 = decrement
//   load       : synchronous parallel load (wins over en)
//   load_digit : digit to load, clamped to 0..9
//   digit      : current digit value
//   term       : digit sits at its terminal code (9 up, 0 down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic up,
  input  logic load,
  input  bcd_t load_digit,
  output bcd_t digit,
  output logic term
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Out-of-range codes are steered back into 0..9 on any step so the
  // register can never dwell on a non-BCD value.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (en) begin
      if (up) begin
        digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else if (digit_q == BCD_MIN || digit_q > BCD_MAX) begin
        digit_d = BCD_MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign term  = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit BCD up/down counter with parallel load and a
// combinational terminal-count carry/borrow for cascading.
//   DIGITS     : number of BCD digits (1..8)
//   WRAP       : 1 = wrap at terminal value, 0 = saturate there
//   clock      : system clock, rising edge
//   reset_n    : synchronous active-low reset, state -> 0
//   count      : count enable
//   up         : 1 = increment, 0 = decrement
//   load       : synchronous parallel load (priority over count)
//   load_value : BCD value to load, digit 0 in [3:0]
//   state      : counter value, digit k in [4k+3:4k]
//   carry      : terminal value reached while counting (carry/borrow)
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    count,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] state,
  output logic                    carry
);

  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] en_chain;
  logic              at_term;
  logic              sat_hold;

  assign at_term  = &term;
  // Saturating variant: freeze every digit while sitting on the terminal
  // value in the current direction; reversing direction releases it.
  assign sat_hold = (WRAP == 1'b0) && at_term;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign en_chain[k] = count & ~sat_hold;
    end else begin : g_next
      assign en_chain[k] = en_chain[k-1] & term[k-1];
    end

    bcd_digit u_digit (
      .clock      (clock),
      .reset_n    (reset_n),
      .en         (en_chain[k]),
      .up         (up),
      .load       (load),
      .load_digit (load_value[BCD_W*k +: BCD_W]),
      .digit      (state[BCD_W*k +: BCD_W]),
      .term       (term[k])
    );
  end

  assign carry = reset_n & count & ~load & at_term;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: four instances (2/WRAP, 2/SAT, 4/WRAP, 1/SAT)
// share one stimulus stream and are compared against integer models.
module tb_bcd_counter_n;

  localparam int NDUT = 4;

  logic        clock = 1'b0;
  logic        reset_n, count, up, load;
  logic [15:0] load_value;

  logic [7:0]  st_a, st_b;
  logic [15:0] st_c;
  logic [3:0]  st_d;
  logic        cy_a, cy_b, cy_c, cy_d;

  always #5 clock = ~clock;

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .count(count), .up(up), .load(load),
    .load_value(load_value[7:0]), .state(st_a), .carry(cy_a));
  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .count(count), .up(up), .load(load),
    .load_value(load_value[7:0]), .state(st_b), .carry(cy_b));
  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut_c (
    .clock(clock), .reset_n(reset_n), .count(count), .up(up), .load(load),
    .load_value(load_value), .state(st_c), .carry(cy_c));
  bcd_counter_n #(.DIGITS(1), .WRAP(1'b0)) dut_d (
    .clock(clock), .reset_n(reset_n), .count(count), .up(up), .load(load),
    .load_value(load_value[3:0]), .state(st_d), .carry(cy_d));

  int unsigned ndig [NDUT] = '{2, 2, 4, 1};
  bit          wrp  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int unsigned mval [NDUT] = '{0, 0, 0, 0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int unsigned pow10(input int unsigned d);
    int unsigned r = 1;
    for (int unsigned i = 0; i < d; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned d);
    logic [31:0] r = '0;
    int unsigned x = v;
    for (int unsigned i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned load_int(input logic [15:0] lv, input int unsigned d);
    int unsigned v = 0;
    int unsigned dg;
    for (int i = int'(d) - 1; i >= 0; i--) begin
      dg = 32'(lv[4*i +: 4]);
      if (dg > 9) dg = 9;
      v = v * 10 + dg;
    end
    return v;
  endfunction

  function automatic logic [31:0] obs_state(input int i);
    case (i)
      0:       return {24'b0, st_a};
      1:       return {24'b0, st_b};
      2:       return {16'b0, st_c};
      default: return {28'b0, st_d};
    endcase
  endfunction

  function automatic logic [31:0] obs_carry(input int i);
    case (i)
      0:       return {31'b0, cy_a};
      1:       return {31'b0, cy_b};
      2:       return {31'b0, cy_c};
      default: return {31'b0, cy_d};
    endcase
  endfunction

  function automatic logic [31:0] model_carry(input int i);
    int unsigned top = pow10(ndig[i]) - 1;
    bit at_end = up ? (mval[i] == top) : (mval[i] == 0);
    return {31'b0, reset_n & count & ~load & at_end};
  endfunction

  task automatic drive(input logic r, input logic c, input logic u, input logic l,
                       input logic [15:0] lv);
    reset_n = r; count = c; up = u; load = l; load_value = lv;
  endtask

  // Inputs are driven at the falling edge; carry is checked just after,
  // state is checked at the following falling edge.
  task automatic cycle(input string name);
    int unsigned top;
    #1;
    for (int i = 0; i < NDUT; i++)
      check($sformatf("%s carry[%0d]", name, i), obs_carry(i), model_carry(i));
    @(posedge clock);
    for (int i = 0; i < NDUT; i++) begin
      top = pow10(ndig[i]) - 1;
      if (!reset_n)   mval[i] = 0;
      else if (load)  mval[i] = load_int(load_value, ndig[i]);
      else if (count) begin
        if (up) mval[i] = (mval[i] == top) ? (wrp[i] ? 0 : top) : mval[i] + 1;
        else    mval[i] = (mval[i] == 0) ? (wrp[i] ? top : 0) : mval[i] - 1;
      end
    end
    @(negedge clock);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("%s state[%0d]", name, i), obs_state(i), to_bcd(mval[i], ndig[i]));
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    @(negedge clock);
    cycle("reset");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); cycle("idle");

    repeat (11) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); cycle("up_run"); end

    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0099); cycle("load99");
    repeat (2) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); cycle("up_term"); end

    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000); cycle("load00");
    repeat (2) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); cycle("down_term"); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); cycle("reverse_up");

    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFA5); cycle("load_clamp");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0098); cycle("load98");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0012); cycle("load_vs_count");

    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h9999); cycle("load_term_cnt");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); cycle("after_load_term");

    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040); cycle("load40");
    repeat (7) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); cycle("up_to47"); end
    repeat (2) begin drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0099); cycle("mid_reset"); end

    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0999); cycle("load0999");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); cycle("ripple_up");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); cycle("ripple_down");

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 15) == 0), 16'($urandom));
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD (decade) counter with count enable, up/down direction, synchronous parallel load and a ripple-free terminal-count carry/borrow output. Each digit is one decade stage; digits cascade internally so the whole counter advances as one decimal number. Used for display counters, event tallies and timebase dividers; carry chains to further instances for wider counts.

## Interface
- DIGITS, 4, number of BCD digits (1..8); counter range 0 .. 10^DIGITS-1
- WRAP, 1, 1 = wrap at terminal value; 0 = saturate at terminal value

- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- count  input  1  synchronous active-high count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous active-high parallel load
- load_value  input  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
- state  output  4*DIGITS  counter value, digit k in bits [4k+3:4k]
- carry  output  1  terminal-count flag (carry when up, borrow when down)

## Operation
- Priority per rising edge: reset_n=0 > load=1 > count=1 > hold.
- Reset: state <= all zeros.
- Load: state <= load_value; any load digit > 9 is stored as 9; count ignored that cycle.
- Count up: digit 0 increments; digit k increments only when digits 0..k-1 are all 9 and count is enabled; a digit at 9 that increments becomes 0.
- Count down: digit 0 decrements; digit k decrements only when digits 0..k-1 are all 0; a digit at 0 that decrements becomes 9.
- Terminal value: all digits 9 (up) or all digits 0 (down).
- WRAP=1: at terminal value, counting wraps (99..9 -> 00..0 up; 00..0 -> 99..9 down).
- WRAP=0: at terminal value, state holds; counting away from terminal (direction reversed) proceeds normally.
- carry = reset_n & count & ~load & (state == terminal value for current up). Combinational, asserted in the same cycle as the wrapping/saturating edge; identical behaviour in both WRAP modes.
- up may change any cycle; takes effect on the next edge and on carry immediately.
- No internal digit ever holds a non-BCD code (10..15) under any input sequence.

## Timing
- Reset values: state = 0, carry = 0 (carry forced 0 while reset_n=0).
- Latency: load or count reflected on state one edge after being sampled.
- carry: zero-cycle (combinational from state, count, up, load, reset_n); downstream instance uses it as its count enable for cascading.
- Reset asserted mid-count: state = 0 at the next edge regardless of count/load.
- Load of a terminal value with count=1: load wins, carry = 0 that cycle; carry asserts next cycle if count still high.
- DIGITS=1 must behave as a plain decade up/down counter.

## Structure
- Shared package bcd_pkg: BCD_MAX = 4'd9, BCD_MIN = 4'd0, BCD digit width constant 4, function for clamping a 4-bit value to 0..9.
- Sub-module bcd_digit: one decade stage; inputs enable, up, load, load digit; outputs digit value, terminal flag (9 when up, 0 when down). Top instantiates DIGITS copies via generate; enable for digit k = count & AND of terminal flags of digits 0..k-1; WRAP handling and global carry in top.

## Test plan
- Reset then count=1, up=1 for 10 cycles, DIGITS=2 -> state 0x00..0x09 then 0x10; carry never asserted.
- DIGITS=2, load 0x99, then count=1 up=1 -> carry=1 in that cycle, next state 0x00 (WRAP=1) or 0x99 held with carry remaining 1 (WRAP=0).
- Load 0x00, count=1 up=0 -> carry=1, next state 0x99 (WRAP=1); 0x00 held (WRAP=0); then up=1 -> 0x01.
- Load 0xA5 (DIGITS=2) -> state 0x95; load with count=1 at 0x98 -> load value wins, no increment.
- Count up to 0x47, assert reset_n=0 with count=1 and load=1 -> state 0x00, carry 0 next cycle and during reset.
- DIGITS=4 from 0x0999 up -> 0x1000 in one edge; from 0x1000 down -> 0x0999; carry 0 both times.
